// File: rtl/project_pkg.sv
// Shared definitions for the matrix entry path: dimension limits, element
// type and range, and the input controller state encoding.
package project_pkg;

  localparam int MAX_ROWS  = 4;
  localparam int MAX_COLS  = 4;
  localparam int ROW_IDX_W = 3;
  localparam int COL_IDX_W = 3;

  typedef logic signed [7:0] matrix_element_t;

  localparam int ELEM_MIN = -9;
  localparam int ELEM_MAX = 9;

  typedef enum logic [2:0] {
    IDLE,
    GET_ROWS,
    GET_COLS,
    SET_DIMS,
    GET_ELEM,
    WRITE,
    PAD,
    DONE
  } mat_in_state_t;

endpackage

// File: rtl/matrix_input_ctrl.sv
// Matrix input controller: collects rows, cols and then row-major element
// tokens from the number parser and issues write strobes to matrix storage.
// An early flush pads the remaining positions with zero.
// Optional: MAT_INPUT_RANGE_CHECK_EN rejects elements outside
// ELEM_MIN..ELEM_MAX with an err_range pulse instead of truncating them.
module matrix_input_ctrl
  import project_pkg::*;
#(
  parameter int unsigned IN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic signed [IN_W-1:0] in_data,
  output logic                  in_ready,
  input  logic                  in_flush,
  output logic                  wr_en,
  output logic                  wr_cmd_set_dims,
  output logic                  wr_cmd_single,
  output logic [ROW_IDX_W-1:0]  wr_dims_r,
  output logic [COL_IDX_W-1:0]  wr_dims_c,
  output logic [ROW_IDX_W-1:0]  wr_row_idx,
  output logic [COL_IDX_W-1:0]  wr_col_idx,
  output matrix_element_t       wr_val_scalar,
  output logic                  busy,
  output logic                  done,
  output logic                  err_dim,
  output logic                  err_range
);

  mat_in_state_t         state_q, state_d;
  logic [ROW_IDX_W-1:0]  rows_q, row_q;
  logic [COL_IDX_W-1:0]  cols_q, col_q;
  matrix_element_t       val_q;
  logic                  err_dim_q;
  logic                  accept;
  logic                  row_ok, col_ok, elem_ok;
  logic                  last_pos;
  int                    tok;

  // Token decode: sign-extended value and the acceptance checks on it.
  always_comb begin
    tok      = int'(in_data);
    row_ok   = (tok >= 1) && (tok <= MAX_ROWS);
    col_ok   = (tok >= 1) && (tok <= MAX_COLS);
`ifdef MAT_INPUT_RANGE_CHECK_EN
    elem_ok  = (tok >= ELEM_MIN) && (tok <= ELEM_MAX);
`else
    elem_ok  = 1'b1;
`endif
    last_pos = (row_q == rows_q - 1'b1) && (col_q == cols_q - 1'b1);
    // abort beats flush beats a token, so ready drops when either is present
    in_ready = !abort &&
               ((state_q == GET_ROWS) || (state_q == GET_COLS) ||
                ((state_q == GET_ELEM) && !in_flush));
    accept   = in_valid && in_ready;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (start) state_d = GET_ROWS;
        GET_ROWS: if (accept && row_ok) state_d = GET_COLS;
        GET_COLS: if (accept && col_ok) state_d = SET_DIMS;
        SET_DIMS: state_d = GET_ELEM;
        GET_ELEM: begin
          if (in_flush)                state_d = PAD;
          else if (accept && elem_ok)  state_d = WRITE;
        end
        WRITE:    state_d = last_pos ? DONE : GET_ELEM;
        PAD:      state_d = last_pos ? DONE : PAD;
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Moore outputs; data fields are zero whenever their strobe is low.
  always_comb begin
    wr_cmd_set_dims = (state_q == SET_DIMS);
    wr_cmd_single   = (state_q == WRITE) || (state_q == PAD);
    wr_en           = wr_cmd_set_dims || wr_cmd_single;
    wr_dims_r       = wr_cmd_set_dims ? rows_q : '0;
    wr_dims_c       = wr_cmd_set_dims ? cols_q : '0;
    wr_row_idx      = wr_cmd_single ? row_q : '0;
    wr_col_idx      = wr_cmd_single ? col_q : '0;
    wr_val_scalar   = (state_q == WRITE) ? val_q : '0;
    busy            = (state_q != IDLE);
    done            = (state_q == DONE);
    err_dim         = err_dim_q;
  end

  // State register, latched dimensions/value and row-major position counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      val_q     <= '0;
      err_dim_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_dim_q <= accept && (((state_q == GET_ROWS) && !row_ok) ||
                              ((state_q == GET_COLS) && !col_ok));
      if ((state_q == GET_ROWS) && accept && row_ok) rows_q <= in_data[ROW_IDX_W-1:0];
      if ((state_q == GET_COLS) && accept && col_ok) cols_q <= in_data[COL_IDX_W-1:0];
      if ((state_q == GET_ELEM) && accept && elem_ok) val_q <= matrix_element_t'(in_data);
      if (state_q == SET_DIMS) begin
        row_q <= '0;
        col_q <= '0;
      end else if ((state_q == WRITE) || (state_q == PAD)) begin
        if (col_q == cols_q - 1'b1) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

`ifdef MAT_INPUT_RANGE_CHECK_EN
  logic err_range_q;

  // Rejected element: one-cycle flag, position and FSM unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) err_range_q <= 1'b0;
    else        err_range_q <= accept && (state_q == GET_ELEM) && !elem_ok;
  end

  always_comb err_range = err_range_q;
`else
  always_comb err_range = 1'b0;
`endif

endmodule

// File: doc/matrix_input_ctrl.md
MATRIX_INPUT_CTRL -- requirements
Module: matrix_input_ctrl

Interface
REQ-001 Parameter IN_W, default 8, width of the signed numeric input token.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset: one clock; synchronous, active-low.
REQ-004 start  input  1  one-cycle pulse that begins a new matrix entry.
REQ-005 abort  input  1  one-cycle pulse that cancels the entry in progress.
REQ-006 in_valid / in_data  input  1 / IN_W (signed)  parsed number token from the input parser.
REQ-007 in_ready  output  1  token accepted when in_valid && in_ready.
REQ-008 in_flush  input  1  end-of-input pulse: the user has stopped typing elements.
REQ-009 wr_en, wr_cmd_set_dims, wr_cmd_single  output  1 each  storage write strobes.
REQ-010 wr_dims_r / wr_dims_c  output  ROW_IDX_W / COL_IDX_W  dimensions, meaningful with set_dims.
REQ-011 wr_row_idx / wr_col_idx  output  ROW_IDX_W / COL_IDX_W  element position, meaningful with single.
REQ-012 wr_val_scalar  output  matrix_element_t  element value.
REQ-013 busy, done, err_dim, err_range  output  1 each  status; done and err_* are one-cycle pulses.

Function
REQ-014 FSM states: IDLE, GET_ROWS, GET_COLS, SET_DIMS, GET_ELEM, WRITE, PAD, DONE.
REQ-015 IDLE: start -> GET_ROWS; tokens are not accepted in IDLE.
REQ-016 in_ready = 1 only in GET_ROWS, GET_COLS and GET_ELEM; busy = 1 in every state except IDLE.
REQ-017 GET_ROWS: an accepted token in 1..MAX_ROWS is latched as rows -> GET_COLS; any other value pulses err_dim and the FSM stays in GET_ROWS.
REQ-018 GET_COLS: same rule against 1..MAX_COLS; a valid value -> SET_DIMS.
REQ-019 SET_DIMS lasts exactly one cycle and drives wr_en = wr_cmd_set_dims = 1 with the latched dimensions (the cycle after cols is accepted); it clears the row/col counters -> GET_ELEM.
REQ-020 GET_ELEM: an accepted token -> WRITE. WRITE lasts one cycle and drives wr_en = wr_cmd_single = 1 with the current row/col indices and the value (latency 1 cycle from acceptance).
REQ-021 Element order is row-major. col increments; at col == cols-1, col wraps to 0 and row increments.
REQ-022 After the write at (rows-1, cols-1) -> DONE. Otherwise WRITE returns to GET_ELEM.
REQ-023 in_flush in GET_ELEM -> PAD. PAD writes 0 to each remaining position, one per cycle with the same strobes, then -> DONE.
REQ-024 in_flush received in GET_ROWS or GET_COLS is ignored.
REQ-025 DONE pulses done for one cycle -> IDLE.
REQ-026 Tokens are never accepted outside the GET_* states. Surplus tokens after the last element therefore stay stalled upstream.
REQ-027 abort in any non-IDLE state -> IDLE next cycle with no further strobes. Storage already allocated is left as is.
REQ-028 abort has priority over in_flush, which has priority over in_valid in the same cycle. start is ignored while busy.
REQ-029 At most one of wr_cmd_set_dims and wr_cmd_single is high in any cycle. All strobes are 0 outside SET_DIMS, WRITE and PAD.

Reset
REQ-030 rst_n = 0 at a clock edge forces IDLE, clears counters and latched dimensions, and sets all outputs to 0. This applies mid-entry as well.

Configuration
REQ-031 With MAT_INPUT_RANGE_CHECK_EN defined: an element outside ELEM_MIN..ELEM_MAX pulses err_range, is not written, and the position does not advance. The FSM stays in GET_ELEM.
REQ-032 Without MAT_INPUT_RANGE_CHECK_EN: elements are truncated to the matrix_element_t width and written, and err_range is tied to 0.

Structure
REQ-033 MAX_ROWS, MAX_COLS, ROW_IDX_W, COL_IDX_W, matrix_element_t, ELEM_MIN, ELEM_MAX and the FSM state enum live in project_pkg.
REQ-034 The block is a single module with no sub-modules. The row-major position counter may be written inline.

Verification
REQ-035 start, tokens 2, 3, then 1..6 -> one set_dims (2,3); six single writes at (0,0)..(1,2) with values 1..6; done pulses 1 cycle after the last write.
REQ-036 start, tokens 0, 7, 2, 2, then 5, then in_flush -> err_dim pulses twice; set_dims (2,2); single writes of 5 at (0,0) then 0 at (0,1), (1,0), (1,1); done pulses.
REQ-037 With the macro defined and ELEM_MAX = 9: rows 1, cols 2, tokens 4, 12, 8 -> err_range pulses once; writes 4 at (0,0) and 8 at (0,1).
REQ-038 abort one cycle after the third element is accepted -> no strobes after that, busy = 0 the next cycle, and a following start restarts cleanly.
REQ-039 rst_n asserted during PAD -> all outputs 0 at the next edge and the FSM is in IDLE; in_valid held high during IDLE is never accepted.
